instr_fetch_issue: RTL and testbench
====================================

Name: instr_fetch_issue

Overview:
- Front end of the multi-cycle microprocessor: fetches 8-bit instruction words from instruction memory and issues the 2-bit opcode plus operand fields to the instruction decoder over a valid/ready handshake.
- Consumes the decoder's Branch response to redirect the program counter on JUMP.
- Maintains the PC, an issued-instruction counter, and a fetch-timeout watchdog.
- Sits between instruction memory and the control/decode stage.

Parameters:
- PC_W, 6, program counter / instruction address width; a JUMP target is ir[5:0], zero-extended or truncated to PC_W.
- TIMEOUT, 15, maximum cycles waiting for imem_ack before error (1..255).
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  single-cycle start pulse, honoured in IDLE only.
- stop  input  1  level; return to IDLE after the current issue handshake.
- imem_req  output  1  fetch request, held until ack.
- imem_addr  output  PC_W  fetch address (= pc while imem_req).
- imem_ack  input  1  read data valid this cycle.
- imem_rdata  input  8  instruction word.
- op_valid  output  1  issued instruction valid.
- op_ready  input  1  decoder accepts instruction.
- op  output  2  ir[7:6]: 00 ADD, 01 LOAD, 10 STORE, 11 JUMP.
- rs  output  2  ir[5:4].
- rt  output  2  ir[3:2].
- rd  output  2  ir[1:0].
- branch  input  1  decoder Branch, valid in the op_valid&op_ready cycle.
- pc  output  PC_W  current program counter.
- issued_cnt  output  CNT_W  count of completed issue handshakes.
- busy  output  1  state != IDLE.
- err  output  1  sticky fetch-timeout flag.

Behaviour:
- Reset, asynchronous, any state:
  - state = IDLE.
  - pc, ir, issued_cnt, watchdog = 0.
  - imem_req, op_valid, busy, err = 0.
  - All outputs are registered or decoded from state/registers; no combinational path from an input to an output.
- IDLE:
  - run=1 → FETCH next cycle.
  - run clears err.
  - pc holds its value; it is not reset by run.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Watchdog increments each cycle without ack.
  - On imem_ack: ir←imem_rdata, pc←pc+1 (wraps 2^PC_W−1→0), watchdog←0 → ISSUE.
  - Ack in the first FETCH cycle is legal (1-cycle fetch).
  - If the watchdog reaches TIMEOUT with no ack: err←1, imem_req drops → IDLE, pc unchanged. The ack test has priority over the timeout test in the same cycle.
- ISSUE:
  - op_valid=1; op/rs/rt/rd are stable from ir until the handshake.
  - On op_valid&op_ready: issued_cnt←issued_cnt+1 (wraps).
  - If branch=1 on that cycle: pc←ir[5:0] (zero-extended/truncated to PC_W), overriding the incremented pc.
  - Next state: IDLE if stop=1 on the handshake cycle, else FETCH.
  - branch is ignored outside the handshake cycle.
  - stop asserted without a handshake has no effect until the handshake.
- Latency:
  - run pulse → imem_req 1 cycle later.
  - ack → op_valid next cycle.
  - handshake → next imem_req next cycle.
  - Minimum 2 cycles per instruction.
- stop in FETCH: ignored; the fetch completes and is issued first.
- run while busy: ignored.
- Mid-operation reset: any outstanding request or issue is abandoned immediately.

Test Plan:
- Reset then run, imem returns 0x00,0x55,0xA7 with 1-cycle ack, op_ready tied 1 → issues op=00; op=01 rs=01 rt=01 rd=01; op=10 rs=10 rt=01 rd=11; pc=3; issued_cnt=3; one issue every 2 cycles.
- Fetch 0xEA (JUMP), decoder drives branch=1 on handshake → next imem_addr=0x2A; pc=0x2A; issued_cnt +1.
- Hold op_ready=0 for 5 cycles in ISSUE → op_valid and fields stable, no imem_req, issued_cnt unchanged; then op_ready=1 → exactly one increment.
- imem_ack withheld with TIMEOUT=15 → imem_req high 15 cycles then drops, err=1, busy=0, pc unchanged; new run → err=0 and fetch retries the same pc.
- pc=63 (PC_W=6), non-jump fetch → pc wraps to 0; stop=1 during the handshake → IDLE, busy=0.
- Assert rst_n=0 mid-FETCH and mid-ISSUE → imem_req, op_valid, pc, issued_cnt all 0 without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue front end: fetches 8-bit words from instruction memory,
// issues opcode and operand fields to the decoder, and redirects the PC on a taken branch.
module instr_fetch_issue #(
   parameter int PC_W    = 6,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             stop,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_ack,
   input  logic [7:0]       imem_rdata,
   output logic             op_valid,
   input  logic             op_ready,
   output logic [1:0]       op,
   output logic [1:0]       rs,
   output logic [1:0]       rt,
   output logic [1:0]       rd,
   input  logic             branch,
   output logic [PC_W-1:0]  pc,
   output logic [CNT_W-1:0] issued_cnt,
   output logic             busy,
   output logic             err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] ISSUE = 2'd2;

   // The watchdog counts completed no-ack cycles, so the request stays up for exactly TIMEOUT cycles.
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   logic [1:0]      state;
   logic [7:0]      ir;
   logic [7:0]      watchdog;
   logic [PC_W-1:0] jump_target;

   assign jump_target = PC_W'(ir[5:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= '0;
         ir         <= '0;
         issued_cnt <= '0;
         watchdog   <= '0;
         err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (run) begin
                  err      <= 1'b0;
                  watchdog <= '0;
                  state    <= FETCH;
               end
            end
            FETCH: begin
               // An ack always wins over a timeout landing in the same cycle.
               if (imem_ack) begin
                  ir       <= imem_rdata;
                  pc       <= pc + PC_W'(1);
                  watchdog <= '0;
                  state    <= ISSUE;
               end else if (watchdog == WD_LAST) begin
                  err      <= 1'b1;
                  watchdog <= '0;
                  state    <= IDLE;
               end else begin
                  watchdog <= watchdog + 8'd1;
               end
            end
            ISSUE: begin
               if (op_ready) begin
                  issued_cnt <= issued_cnt + CNT_W'(1);
                  if (branch) begin
                     pc <= jump_target;
                  end
                  state <= stop ? IDLE : FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;
   assign op_valid  = (state == ISSUE);
   assign busy      = (state != IDLE);
   assign op        = ir[7:6];
   assign rs        = ir[5:4];
   assign rt        = ir[3:2];
   assign rd        = ir[1:0];

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Testbench for instr_fetch_issue: acts as instruction memory and decoder, and predicts
// PC, issue count and fields at transaction level.
module tb_instr_fetch_issue;

   localparam int PC_W     = 6;
   localparam int TIMEOUT  = 15;
   localparam int CNT_W    = 16;
   localparam int PC_MASK  = (1 << PC_W) - 1;
   localparam int CNT_MASK = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n, run, stop, imem_ack, op_ready, branch;
   logic [7:0]       imem_rdata;
   logic             imem_req, op_valid, busy, err;
   logic [PC_W-1:0]  imem_addr, pc;
   logic [1:0]       op, rs, rt, rd;
   logic [CNT_W-1:0] issued_cnt;

   int errors = 0;
   int checks = 0;
   int m_pc   = 0;
   int m_cnt  = 0;
   bit running = 1'b0;

   always #5 clk = ~clk;

   instr_fetch_issue #(.PC_W(PC_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .stop(stop),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .op_valid(op_valid), .op_ready(op_ready), .op(op), .rs(rs), .rt(rt), .rd(rd),
      .branch(branch), .pc(pc), .issued_cnt(issued_cnt), .busy(busy), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start();
      run = 1'b1;
      step();
      run = 1'b0;
      running = 1'b1;
      chk("run_req", imem_req, 1);
      chk("run_busy", busy, 1);
      chk("run_addr", imem_addr, m_pc);
   endtask

   // Called with the DUT in its first FETCH cycle; serves one instruction end to end.
   task automatic fetch_issue(input logic [7:0] w, input int lat, input int wait_n,
                              input bit br, input bit stp);
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, m_pc);
      for (int i = 0; i < lat; i++) begin
         stop = 1'($urandom_range(0, 1));
         run  = 1'($urandom_range(0, 1));
         step();
         chk("fetch_hold", imem_req, 1);
         chk("fetch_no_valid", op_valid, 0);
         chk("fetch_addr_hold", imem_addr, m_pc);
      end
      imem_ack   = 1'b1;
      imem_rdata = w;
      stop       = 1'($urandom_range(0, 1));
      step();
      imem_ack   = 1'b0;
      imem_rdata = 8'($urandom);
      run        = 1'b0;
      m_pc = (m_pc + 1) & PC_MASK;
      chk("issue_valid", op_valid, 1);
      chk("issue_no_req", imem_req, 0);
      chk("issue_fields", {op, rs, rt, rd}, w);
      chk("issue_pc", pc, m_pc);
      op_ready = 1'b0;
      for (int i = 0; i < wait_n; i++) begin
         branch = 1'($urandom_range(0, 1));
         stop   = 1'($urandom_range(0, 1));
         run    = 1'($urandom_range(0, 1));
         step();
         chk("stall_valid", op_valid, 1);
         chk("stall_fields", {op, rs, rt, rd}, w);
         chk("stall_no_req", imem_req, 0);
         chk("stall_cnt", issued_cnt, m_cnt);
         chk("stall_pc", pc, m_pc);
      end
      run      = 1'b0;
      op_ready = 1'b1;
      branch   = br;
      stop     = stp;
      step();
      op_ready = 1'b0;
      branch   = 1'b0;
      stop     = 1'b0;
      m_cnt = (m_cnt + 1) & CNT_MASK;
      if (br) m_pc = int'(w[5:0]) & PC_MASK;
      chk("hs_cnt", issued_cnt, m_cnt);
      chk("hs_pc", pc, m_pc);
      chk("hs_valid_drop", op_valid, 0);
      if (stp) begin
         running = 1'b0;
         chk("stop_busy", busy, 0);
         chk("stop_req", imem_req, 0);
      end else begin
         chk("next_req", imem_req, 1);
         chk("next_addr", imem_addr, m_pc);
      end
   endtask

   task automatic check_async_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_req"}, imem_req, 0);
      chk({tag, "_valid"}, op_valid, 0);
      chk({tag, "_pc"}, pc, 0);
      chk({tag, "_cnt"}, issued_cnt, 0);
      chk({tag, "_busy"}, busy, 0);
      m_pc = 0;
      m_cnt = 0;
      running = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk({tag, "_idle_after"}, busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; run = 1'b0; stop = 1'b0; imem_ack = 1'b0;
      imem_rdata = 8'h00; op_ready = 1'b0; branch = 1'b0;
      step();
      step();
      chk("rst_req", imem_req, 0);
      chk("rst_valid", op_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_pc", pc, 0);
      chk("rst_cnt", issued_cnt, 0);
      rst_n = 1'b1;
      step();
      chk("idle_no_req", imem_req, 0);

      // Straight-line program, one issue every two cycles.
      start();
      fetch_issue(8'h00, 0, 0, 1'b0, 1'b0);
      fetch_issue(8'h55, 0, 0, 1'b0, 1'b0);
      fetch_issue(8'hA7, 0, 0, 1'b0, 1'b1);
      chk("prog_pc", pc, 3);
      chk("prog_cnt", issued_cnt, 3);

      // Jump redirect, then a stalled decoder.
      start();
      fetch_issue(8'hEA, 0, 0, 1'b1, 1'b0);
      chk("jump_addr", imem_addr, 8'h2A);
      fetch_issue(8'h1B, 2, 5, 1'b0, 1'b1);

      // Jump to the top address, then a late ack on the last legal cycle and PC wrap.
      start();
      fetch_issue(8'hFF, 0, 0, 1'b1, 1'b0);
      chk("top_pc", pc, 63);
      fetch_issue(8'h24, TIMEOUT - 1, 0, 1'b0, 1'b1);
      chk("wrap_pc", pc, 0);
      chk("wrap_idle", busy, 0);

      // Fetch timeout and retry of the same address.
      start();
      for (int i = 1; i < TIMEOUT; i++) begin
         step();
         chk("to_req_hold", imem_req, 1);
         chk("to_err_low", err, 0);
      end
      step();
      running = 1'b0;
      chk("to_req_drop", imem_req, 0);
      chk("to_err", err, 1);
      chk("to_busy", busy, 0);
      chk("to_pc", pc, m_pc);
      step();
      chk("to_err_sticky", err, 1);
      start();
      chk("retry_err_clr", err, 0);
      fetch_issue(8'h9C, 1, 1, 1'b0, 1'b1);

      // Randomised traffic.
      for (int n = 0; n < 60; n++) begin
         logic [7:0] w;
         bit br, stp;
         w   = 8'($urandom);
         br  = (w[7:6] == 2'b11) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 7) == 0);
         stp = ($urandom_range(0, 4) == 0);
         if (!running) start();
         fetch_issue(w, $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3), br, stp);
      end

      // Asynchronous reset in the middle of a fetch.
      if (!running) start();
      step();
      chk("pre_rst_fetch", imem_req, 1);
      check_async_reset("rst_fetch");

      // Asynchronous reset in the middle of an issue.
      start();
      fetch_issue(8'h4D, 0, 0, 1'b0, 1'b0);
      imem_ack   = 1'b1;
      imem_rdata = 8'h13;
      step();
      imem_ack   = 1'b0;
      chk("pre_rst_issue", op_valid, 1);
      check_async_reset("rst_issue");

      start();
      fetch_issue(8'h61, 0, 0, 1'b0, 1'b1);
      chk("recover_pc", pc, 1);
      chk("recover_cnt", issued_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
